// File: rtl/dvv_bus_resp.sv
// ---------------------------------------------------------------------------
// dvv_bus_resp
// Bus responder (target) for the dvv valid/ready request/response bus.
// Accepts one read or write at a time, holds it for WAIT_CYC wait states and
// then presents a response. The backing store is a DEPTH-word register file
// with per-byte write enables. Only one transaction is ever outstanding.
//
// Optional feature macro: DVV_RESP_ERR_EN
//   defined   : addresses >= DEPTH are out of range. The write is dropped,
//               rdata is 0 and resp_err is 1.
//   undefined : upper address bits are ignored, so addresses alias modulo
//               DEPTH. resp_err is constant 0.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active high
//   req_valid   request valid            req_ready  responder can accept
//   req_we      1 = write, 0 = read      req_addr   word address
//   req_wdata   write data               req_be     byte enables (writes)
//   resp_valid  response valid           resp_ready initiator takes response
//   resp_rdata  read data (0 for writes) resp_err   out-of-range flag
//   busy        transaction in flight    txn_cnt    completed handshakes
// ---------------------------------------------------------------------------
module dvv_bus_resp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 2,
    parameter int TXN_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic [TXN_W-1:0]      txn_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                busy_q, busy_d;
    logic [TXN_W-1:0]    txn_cnt_q, txn_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [IDX_W-1:0]    idx_s;
    logic                oor_s;

    // Merge new write data into an old word, byte lane by byte lane.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign idx_s = addr_q[IDX_W-1:0];

`ifdef DVV_RESP_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    assign oor_s = ({1'b0, addr_q} >= DEPTH_EXT);
`else
    // Upper address bits alias; fold them into a deliberately unused net.
    logic unused_addr_s;
    assign unused_addr_s = ^addr_q;
    assign oor_s         = 1'b0;
`endif

    // Ready only in IDLE and never while reset is being applied.
    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign txn_cnt    = txn_cnt_q;

    // Next-state, request latch, commit and response logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        txn_cnt_d    = txn_cnt_q;
        mem_d        = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    // The cycle after the accept edge is spent in WAIT even
                    // with zero wait states, giving accept-to-valid of
                    // 1 + WAIT_CYC edges.
                    cnt_d   = 8'(WAIT_CYC);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    if (oor_s) begin
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_d[idx_s] = be_merge(mem_q[idx_s], wdata_q, be_q);
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                    end else begin
                        resp_rdata_d = mem_q[idx_s];
                        resp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    txn_cnt_d    = txn_cnt_q + {{(TXN_W-1){1'b0}}, 1'b1};
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, latched request, response and register file flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            txn_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            txn_cnt_q    <= txn_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
